// File: rtl/core_pkg.sv
// Shared pipeline-control definitions for the 5-stage core.
package core_pkg;

   localparam int unsigned REG_AW = 5;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      StRun,
      StLuStall,
      StMemWait
   } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID instruction's sources and a load in EX.
module hazard_detect #(
   parameter int unsigned AW = 5
) (
   input  logic [AW-1:0] id_rs1_i,
   input  logic [AW-1:0] id_rs2_i,
   input  logic          id_use_rs1_i,
   input  logic          id_use_rs2_i,
   input  logic [AW-1:0] ex_rd_i,
   input  logic          ex_mem_read_i,
   output logic          lu_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign lu_o = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush control: load-use stalls, branch squash, dmem freeze,
// plus a saturating stall counter and a sticky memory-timeout flag.
module hazard_stall_ctrl #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_branch_taken,
   input  logic              dmem_busy,
   output logic              pc_write_en,
   output logic              ifid_write_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              pipe_freeze,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic              mem_timeout
);

   import core_pkg::*;

   localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
   logic             lu;
   logic             run_eval;

   hazard_detect #(
      .AW(REG_AW)
   ) u_hazard_detect (
      .id_rs1_i     (id_rs1),
      .id_rs2_i     (id_rs2),
      .id_use_rs1_i (id_use_rs1),
      .id_use_rs2_i (id_use_rs2),
      .ex_rd_i      (ex_rd),
      .ex_mem_read_i(ex_mem_read),
      .lu_o         (lu)
   );

   always_comb begin
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      pipe_freeze   = 1'b0;
      state_d       = state_q;
      wait_d        = wait_q;
      run_eval      = 1'b0;

      unique case (state_q)
         StRun: run_eval = 1'b1;
         StLuStall: begin
            if (dmem_busy) begin
               pipe_freeze   = 1'b1;
               pc_write_en   = 1'b0;
               ifid_write_en = 1'b0;
               state_d       = StMemWait;
               wait_d        = WaitW'(1);
            end else begin
               state_d = StRun;
            end
         end
         StMemWait: begin
            if (dmem_busy) begin
               pipe_freeze   = 1'b1;
               pc_write_en   = 1'b0;
               ifid_write_en = 1'b0;
               if (wait_q != WaitMax) wait_d = wait_q + WaitW'(1);
            end else begin
               // Release cycle behaves exactly like RUN, so a held branch flushes now.
               run_eval = 1'b1;
               wait_d   = '0;
            end
         end
         default: state_d = StRun;
      endcase

      if (run_eval) begin
         state_d = StRun;
         if (dmem_busy) begin
            pipe_freeze   = 1'b1;
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            state_d       = StMemWait;
            wait_d        = WaitW'(1);
         end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (lu) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_flush    = 1'b1;
            state_d       = StLuStall;
         end
      end

      // Outputs must show reset values as soon as rst_n drops, not at the next edge.
      if (!rst_n) begin
         pc_write_en   = 1'b1;
         ifid_write_en = 1'b1;
         ifid_flush    = 1'b0;
         idex_flush    = 1'b0;
         pipe_freeze   = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if ((!pc_write_en || ifid_flush) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      tmo_d = tmo_q || (wait_d == WaitMax);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         wait_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign stall_cnt   = cnt_q;
   assign mem_timeout = tmo_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;

   localparam int unsigned AW = 5;
   localparam int unsigned CW = 7;

   localparam logic [4:0] CtlDef = 5'b11000;
   localparam logic [4:0] CtlLu  = 5'b00010;
   localparam logic [4:0] CtlBr  = 5'b11110;
   localparam logic [4:0] CtlFrz = 5'b00001;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] id_rs1, id_rs2, ex_rd;
   logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, dmem_busy;
   logic          pc_write_en, ifid_write_en, ifid_flush, idex_flush, pipe_freeze;
   logic [CW-1:0] stall_cnt;
   logic          mem_timeout;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(
      .REG_AW (AW),
      .TIMEOUT(64),
      .CNT_W  (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_use_rs1     (id_use_rs1),
      .id_use_rs2     (id_use_rs2),
      .ex_rd          (ex_rd),
      .ex_mem_read    (ex_mem_read),
      .ex_branch_taken(ex_branch_taken),
      .dmem_busy      (dmem_busy),
      .pc_write_en    (pc_write_en),
      .ifid_write_en  (ifid_write_en),
      .ifid_flush     (ifid_flush),
      .idex_flush     (idex_flush),
      .pipe_freeze    (pipe_freeze),
      .stall_cnt      (stall_cnt),
      .mem_timeout    (mem_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [4:0] exp);
      chk(tag, {27'd0, pc_write_en, ifid_write_en, ifid_flush, idex_flush, pipe_freeze},
          {27'd0, exp});
   endtask

   task automatic clr();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; dmem_busy = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after a posedge: drops rst_n mid-cycle, checks, releases.
   task automatic pulse_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk_ctl({tag, "_ctl"}, CtlDef);
      chk({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
      chk({tag, "_tmo"}, 32'(mem_timeout), 32'd0);
      clr();
      #1 rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      clr();
      rst_n = 1'b0;
      #1;
      chk_ctl("reset_ctl", CtlDef);
      chk("reset_cnt", 32'(stall_cnt), 32'd0);
      chk("reset_tmo", 32'(mem_timeout), 32'd0);
      #11 rst_n = 1'b1;
      cyc();
      #1 chk_ctl("idle_ctl", CtlDef);

      // Load-use via rs2
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
      #1 chk_ctl("lu_rs2_ctl", CtlLu);
      cyc();
      #1 chk_ctl("lu_stall_ctl", CtlDef);
      chk("lu_cnt", 32'(stall_cnt), 32'd1);
      clr();
      cyc();

      // Register matches but source not used, then x-width mismatch, then rs1 hazard
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd7;
      #1 chk_ctl("lu_unused_ctl", CtlDef);
      ex_rd = 5'b10101; id_rs1 = 5'b00101; id_use_rs1 = 1'b1;
      #1 chk_ctl("lu_msb_ctl", CtlDef);
      ex_rd = 5'd7; id_rs1 = 5'd7;
      #1 chk_ctl("lu_rs1_ctl", CtlLu);
      cyc();
      clr();
      cyc();
      chk("lu_rs1_cnt", 32'(stall_cnt), 32'd2);

      // Branch squashes simultaneous load-use; no LU_STALL follows
      ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
      ex_branch_taken = 1'b1;
      #1 chk_ctl("br_lu_ctl", CtlBr);
      cyc();
      ex_branch_taken = 1'b0;
      #1 chk_ctl("br_after_ctl", CtlLu);
      cyc();
      chk("br_cnt", 32'(stall_cnt), 32'd4);
      clr();
      cyc();

      // x0 immunity
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      #1 chk_ctl("x0_ctl", CtlDef);
      cyc();
      chk("x0_cnt", 32'(stall_cnt), 32'd4);
      clr();

      pulse_reset("rst1");

      // Memory wait with a branch held in EX
      dmem_busy = 1'b1; ex_branch_taken = 1'b1;
      #1 chk_ctl("mw_c1_ctl", CtlFrz);
      cyc();
      #1 chk_ctl("mw_c2_ctl", CtlFrz);
      cyc();
      #1 chk_ctl("mw_c3_ctl", CtlFrz);
      cyc();
      dmem_busy = 1'b0;
      #1 chk_ctl("mw_release_ctl", CtlBr);
      cyc();
      chk("mw_cnt", 32'(stall_cnt), 32'd4);
      ex_branch_taken = 1'b0;
      #1 chk_ctl("mw_after_ctl", CtlDef);

      // Timeout after 64 consecutive busy cycles
      dmem_busy = 1'b1;
      for (int i = 0; i < 63; i++) cyc();
      chk("tmo_63", 32'(mem_timeout), 32'd0);
      cyc();
      chk("tmo_64", 32'(mem_timeout), 32'd1);
      for (int i = 0; i < 6; i++) cyc();
      dmem_busy = 1'b0;
      #1 chk_ctl("tmo_release_ctl", CtlDef);
      cyc();
      chk("tmo_sticky", 32'(mem_timeout), 32'd1);
      chk("tmo_cnt", 32'(stall_cnt), 32'd74);

      // Counter saturation at all-ones
      dmem_busy = 1'b1;
      for (int i = 0; i < 60; i++) cyc();
      chk("sat_cnt", 32'(stall_cnt), 32'd127);
      dmem_busy = 1'b0;
      cyc();
      chk("sat_hold", 32'(stall_cnt), 32'd127);

      // Async reset in the middle of MEM_WAIT
      dmem_busy = 1'b1;
      cyc();
      #1 chk_ctl("rst_mw_pre", CtlFrz);
      @(posedge clk);
      #1;
      pulse_reset("rst_mw");
      #1 chk_ctl("rst_mw_post", CtlDef);
      chk("rst_mw_cnt_post", 32'(stall_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
